delay_cfg_loader: RTL and testbench
===================================

# delay_cfg_loader

Deserialises the scan-in delay configuration stream (`i_delay_en` / `i_delay_cfg`) into the flat keyring + mul/div delay-select word.
- Sits directly behind the top-level scan pins and feeds the keyring delay elements.
- Validates the bit count of each load.
- Commits the new word atomically through a shadow register.
- Flags the core as configured only after a clean commit.

## Interface
Parameters:
- `N_BITS`, default 195: total configuration bits, equal to `KEYRING_DE_FLAT` = (ExS + 3) × L.
- `CNT_W`, default `$clog2(N_BITS+2)`: width of the bit counter.

Ports:
- `i_clk`, input, 1: system clock; all state changes on the rising edge.
- `i_rstn`, input, 1: reset, asynchronous, active-low.
- `i_delay_en`, input, 1: scan enable; a bit is sampled on every rising edge while it is high.
- `i_delay_cfg`, input, 1: serial configuration bit.
- `o_delay_flat`, output, `N_BITS`: committed delay word driving the delay lines.
- `o_cfg_done`, output, 1: at least one successful commit has completed since reset.
- `o_cfg_err`, output, 1: sticky flag; the last load had a wrong bit count.
- `o_busy`, output, 1: a load is in progress (SHIFT or CHECK state).

## Operation
- **Shift register `sh`** (`N_BITS`):
  - Each sampled bit is shifted in at the MSB: `sh <= {i_delay_cfg, sh[N_BITS-1:1]}`.
  - After exactly `N_BITS` samples, the first bit received sits at bit 0 and the last at bit `N_BITS-1`.
- **Bit counter `cnt`**:
  - Cleared on entry to SHIFT.
  - Increments per sample and saturates at `N_BITS+1`, so the counter never wraps.
- **FSM states**: IDLE, SHIFT, CHECK, COMMIT.
  - IDLE:
    - `i_delay_en`=1 → SHIFT.
    - On that same edge: sample bit 1, set `cnt`=1, clear `o_cfg_err`.
  - SHIFT:
    - While `i_delay_en`=1: sample and count.
    - `i_delay_en`=0 → CHECK; no sample is taken on that edge.
  - CHECK:
    - `cnt`==`N_BITS` → COMMIT.
    - Otherwise → IDLE with `o_cfg_err`=1. `o_delay_flat` and `o_cfg_done` are unchanged.
    - If `i_delay_en` is re-asserted during CHECK, it is ignored until IDLE.
  - COMMIT:
    - `o_delay_flat <= sh`.
    - `o_cfg_done <= 1`.
    - → IDLE unconditionally.
- **`o_delay_flat` stability**: it changes only in COMMIT. A partial or failed load never disturbs the delay lines.
- **Reloads**: a new load after `o_cfg_done`=1 is legal. `o_cfg_done` stays 1 throughout; `o_delay_flat` switches in a single cycle on the next successful COMMIT.
- **`o_busy`**: equals (state == SHIFT or state == CHECK).
- **Reset** (asynchronous, at any time, including mid-load):
  - State → IDLE.
  - `sh` = 0, `cnt` = 0.
  - `o_delay_flat` = 0, `o_cfg_done` = 0, `o_cfg_err` = 0, `o_busy` = 0.
  - Partial data is discarded.

## Timing
- **Sampling**: `i_delay_cfg` must be stable around the rising edge. The stream source drives on the falling edge.
- **Latency** from the last sampled edge (edge k):
  - Edge k+1: `i_delay_en` seen low, → CHECK.
  - Edge k+2: → COMMIT.
  - Edge k+3: `o_delay_flat` and `o_cfg_done` updated.
  - Total: 3 cycles after the last bit.
- **Error path**: `o_cfg_err` rises at edge k+2.
- **Enable pulses**:
  - Minimum pulse is 1 cycle, giving 1 bit and therefore an error unless `N_BITS`=1.
  - Back-to-back loads: `i_delay_en` may re-rise from the first edge at which the FSM is in IDLE.
- **Overflow**: more than `N_BITS` samples leave `cnt`=`N_BITS+1`, which is an error. The shift register keeps shifting, but nothing is committed.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Nominal load**: reset, then stream `N_BITS` bits of pattern `bit[i] = i%3==0`.
  - Required: `o_delay_flat[i]` = pattern[i] for every i.
  - `o_cfg_done` rises 3 cycles after the last bit; `o_cfg_err`=0; `o_busy` is high from the first sample until COMMIT.
- **Short load**: stream `N_BITS-1` bits of all 1s after a committed all-0s word.
  - Required: `o_cfg_err`=1 at k+2; `o_delay_flat` stays all 0s.
- **Long load**: stream `N_BITS+5` bits.
  - Required: `o_cfg_err`=1; no commit; `cnt` does not wrap. With `N_BITS`=3, a 20-bit stream must still flag an error.
- **Reload**: commit 0xAAA…, then load 0x555….
  - Required: `o_cfg_done` stays 1 throughout; `o_delay_flat` holds 0xAAA… until the single-cycle switch to 0x555…; the next clean load clears `o_cfg_err`.
- **Reset mid-load**: assert `i_rstn`=0 after 50 bits, asynchronously between edges.
  - Required: all outputs are 0 immediately.
  - After release, a full clean load commits correctly with no residue from the partial load.
- **Back-to-back**: re-assert `i_delay_en` during CHECK and then during IDLE.
  - Required: the CHECK assertion is ignored; the IDLE assertion starts a new load with `cnt`=1.

Source files
------------

// File: rtl/delay_cfg_loader.sv
// Serial-to-parallel loader for the keyring delay configuration word.
// Checks the bit count of every load and commits the word only when the count is exact.
module delay_cfg_loader #(
  parameter int N_BITS = 195,
  parameter int CNT_W  = $clog2(N_BITS + 2)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_delay_en,
  input  logic              i_delay_cfg,
  output logic [N_BITS-1:0] o_delay_flat,
  output logic              o_cfg_done,
  output logic              o_cfg_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N_BITS + 1);

  state_t            state_q, state_d;
  logic [N_BITS-1:0] sh_q, sh_d;
  logic [N_BITS-1:0] flat_q, flat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      flat_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      flat_q  <= flat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_delay_en) state_d = ST_SHIFT;
      ST_SHIFT:  if (!i_delay_en) state_d = ST_CHECK;
      ST_CHECK:  state_d = (cnt_q == CNT_FULL) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Busy is registered from the next state so it still tracks SHIFT/CHECK exactly.
  always_comb begin
    sh_d   = sh_q;
    flat_d = flat_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    err_d  = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_delay_en) begin
          sh_d  = N_BITS'({i_delay_cfg, sh_q} >> 1);
          cnt_d = CNT_ONE;
          err_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (i_delay_en) begin
          sh_d = N_BITS'({i_delay_cfg, sh_q} >> 1);
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (cnt_q != CNT_FULL) err_d = 1'b1;
      end
      ST_COMMIT: begin
        flat_d = sh_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
  end

  assign o_delay_flat = flat_q;
  assign o_cfg_done   = done_q;
  assign o_cfg_err    = err_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_delay_cfg_loader.sv
// Directed bench for delay_cfg_loader: a default-size instance plus a 3-bit instance for overflow.
// Expected commit results are queued as each load is streamed and popped when the commit lands.
module tb_delay_cfg_loader;

  localparam int N = 195;

  typedef struct {
    string      tag;
    logic [N-1:0] flat;
    logic       done;
    logic       err;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic         en, cfg;
  logic [N-1:0] flat;
  logic         done, err, busy;
  logic         enS, cfgS;
  logic [2:0]   flatS;
  logic         doneS, errS, busyS;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  logic [N-1:0] patNom, patA, patB, patC, patD, patE, allOnes;

  delay_cfg_loader #(.N_BITS(N)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_delay_en  (en),
    .i_delay_cfg (cfg),
    .o_delay_flat(flat),
    .o_cfg_done  (done),
    .o_cfg_err   (err),
    .o_busy      (busy)
  );

  delay_cfg_loader #(.N_BITS(3)) dutSmall (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_delay_en  (enS),
    .i_delay_cfg (cfgS),
    .o_delay_flat(flatS),
    .o_cfg_done  (doneS),
    .o_cfg_err   (errS),
    .o_busy      (busyS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [N-1:0] f, input logic d, input logic e);
    exp_t x;
    x.tag = tag; x.flat = f; x.done = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic checkScoreboard();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1 entry");
    end else begin
      x = sb.pop_front();
      checkOutput({x.tag, "_flat"}, flat, x.flat);
      checkOutput({x.tag, "_done"}, N'(done), N'(x.done));
      checkOutput({x.tag, "_err"}, N'(err), N'(x.err));
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows the last sample.
  task automatic applyStimulus(input logic [N-1:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      en  = 1'b1;
      cfg = (i < N) ? data[i] : 1'b1;
      @(negedge clk);
    end
    checkOutput("stream_busy", N'(busy), N'(1));
    en  = 1'b0;
    cfg = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; cfg = 1'b0; enS = 1'b0; cfgS = 1'b0;
    for (int i = 0; i < N; i++) begin
      patNom[i]  = (i % 3 == 0);
      patA[i]    = (i % 2 == 1);
      patB[i]    = (i % 2 == 0);
      patC[i]    = 1'($urandom);
      patD[i]    = 1'($urandom);
      patE[i]    = 1'($urandom);
      allOnes[i] = 1'b1;
    end

    #3;
    checkOutput("reset_flat", flat, '0);
    checkOutput("reset_done", N'(done), '0);
    checkOutput("reset_err", N'(err), '0);
    checkOutput("reset_busy", N'(busy), '0);
    checkOutput("reset_small_flat", N'(flatS), '0);
    @(negedge clk);
    rstn = 1'b1;

    // Nominal load, with cycle-by-cycle latency checks
    applyStimulus(patNom, N);
    pushExpected("nominal", patNom, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("nom_k1_busy", N'(busy), N'(1));
    checkOutput("nom_k1_done", N'(done), '0);
    @(negedge clk);
    checkOutput("nom_k2_busy", N'(busy), '0);
    checkOutput("nom_k2_done", N'(done), '0);
    checkOutput("nom_k2_flat", flat, '0);
    @(negedge clk);
    checkScoreboard();

    applyStimulus('0, N);
    pushExpected("zeros", '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkScoreboard();

    // Short load
    applyStimulus(allOnes, N - 1);
    pushExpected("short", '0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("short_k1_err", N'(err), '0);
    @(negedge clk);
    checkOutput("short_k2_err", N'(err), N'(1));
    checkOutput("short_k2_flat", flat, '0);
    @(negedge clk);
    checkScoreboard();

    // Long load
    applyStimulus(allOnes, N + 5);
    pushExpected("long", '0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkScoreboard();

    // Reload A then B
    applyStimulus(patA, N);
    checkOutput("reload_err_cleared", N'(err), '0);
    pushExpected("reloadA", patA, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkScoreboard();
    applyStimulus(patB, N);
    checkOutput("reload_hold_flat", flat, patA);
    checkOutput("reload_hold_done", N'(done), N'(1));
    pushExpected("reloadB", patB, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("reload_k1_flat", flat, patA);
    @(negedge clk);
    checkOutput("reload_k2_flat", flat, patA);
    checkOutput("reload_k2_done", N'(done), N'(1));
    @(negedge clk);
    checkScoreboard();

    // Back-to-back: enable raised during CHECK and held through COMMIT into IDLE
    applyStimulus(patC, N);
    pushExpected("b2b_first", patC, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("b2b_check_busy", N'(busy), N'(1));
    en = 1'b1; cfg = 1'b1;
    @(negedge clk);
    checkOutput("b2b_commit_busy", N'(busy), '0);
    @(negedge clk);
    checkScoreboard();
    applyStimulus(patD, N);
    pushExpected("b2b_second", patD, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkScoreboard();

    // Asynchronous reset after 50 bits
    for (int i = 0; i < 50; i++) begin
      en = 1'b1; cfg = 1'($urandom);
      @(negedge clk);
    end
    #2;
    rstn = 1'b0; en = 1'b0; cfg = 1'b0;
    #1;
    checkOutput("midreset_flat", flat, '0);
    checkOutput("midreset_done", N'(done), '0);
    checkOutput("midreset_err", N'(err), '0);
    checkOutput("midreset_busy", N'(busy), '0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(patE, N);
    pushExpected("after_reset", patE, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkScoreboard();

    // 3-bit instance: clean load of 3'b101, then a 20-bit overflow stream
    for (int i = 0; i < 3; i++) begin
      enS = 1'b1; cfgS = (i != 1);
      @(negedge clk);
    end
    enS = 1'b0; cfgS = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("small_flat", N'(flatS), N'(3'b101));
    checkOutput("small_done", N'(doneS), N'(1));
    checkOutput("small_err", N'(errS), '0);
    for (int i = 0; i < 20; i++) begin
      enS = 1'b1; cfgS = 1'(i % 2);
      @(negedge clk);
    end
    enS = 1'b0; cfgS = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("small_ovf_err", N'(errS), N'(1));
    @(negedge clk);
    checkOutput("small_ovf_flat", N'(flatS), N'(3'b101));
    checkOutput("small_ovf_done", N'(doneS), N'(1));
    checkOutput("small_ovf_busy", N'(busyS), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
